regfile_wr_arb: RTL and testbench

Write-port arbiter and scheduler for the 32×64 register file. Several writeback sources (ALU writeback, load writeback, multi-cycle multiply/divide unit) compete for the file's single write port. This block grants one source per cycle using round-robin priority, with an optional bounded lock for paired writes. It registers the winning write onto the `RegWrite`/`WriteRegister`/`WriteData` port, and sits between the pipeline's writeback stage and the register file.

---
 rtl/rf_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/regfile_wr_arb.sv | 124 ++++++++++++
 tb/tb_regfile_wr_arb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared constants and state type for the register-file write arbiter
package rf_arb_pkg;

  localparam logic [4:0] ZERO_REG = 5'd31;
  localparam int         REG_AW   = 5;
  localparam int         REG_DW   = 64;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts at start_i and wraps
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] start_i,
  output logic [N-1:0]  gnt_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, start_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// rtl/regfile_wr_arb.sv - round-robin write-port arbiter with bounded lock and staged write
// Optional forwarding compare ports are built only when RF_ARB_FWD_EN is defined.
module regfile_wr_arb
  import rf_arb_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int LOCK_MAX = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_lock,
  input  logic [NREQ-1:0][REG_AW-1:0]  req_addr,
  input  logic [NREQ-1:0][REG_DW-1:0]  req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic                         RegWrite,
  output logic [REG_AW-1:0]            WriteRegister,
  output logic [REG_DW-1:0]            WriteData
`ifdef RF_ARB_FWD_EN
  ,
  input  logic [REG_AW-1:0]            fwd_addr1,
  input  logic [REG_AW-1:0]            fwd_addr2,
  output logic                         fwd_hit1,
  output logic                         fwd_hit2,
  output logic [REG_DW-1:0]            fwd_data
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [2:0]        lcnt_q, lcnt_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [REG_DW-1:0] wdata_q, wdata_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [NREQ-1:0]   gnt;
  logic [PW-1:0]     gidx;
  logic              xfer;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req_i   (req_valid),
    .start_i (ptr_q),
    .gnt_o   (pick_gnt)
  );

  always_comb begin
    gnt = '0;
    if (state_q == IDLE) gnt = pick_gnt;
    else if (req_valid[owner_q]) gnt[owner_q] = 1'b1;
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gidx = PW'(i);
    end
    xfer = |gnt;
  end

  assign req_ready = reset_n ? gnt : '0;

  // lcnt counts grants already held by the owner, so the owner never exceeds LOCK_MAX in a row
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    lcnt_d  = lcnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (xfer) begin
      we_d    = (req_addr[gidx] != ZERO_REG);
      waddr_d = req_addr[gidx];
      wdata_d = req_data[gidx];
      ptr_d   = (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
    end
    if (state_q == IDLE) begin
      if (xfer && req_lock[gidx] && (LOCK_MAX > 1)) begin
        state_d = LOCKED;
        owner_d = gidx;
        lcnt_d  = 3'd1;
      end
    end else begin
      if (xfer && req_lock[owner_q] && (int'(lcnt_q) + 1 < LOCK_MAX)) begin
        lcnt_d = lcnt_q + 3'd1;
      end else begin
        state_d = IDLE;
        lcnt_d  = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      lcnt_q  <= 3'd0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      lcnt_q  <= lcnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign RegWrite      = we_q;
  assign WriteRegister = waddr_q;
  assign WriteData     = wdata_q;

`ifdef RF_ARB_FWD_EN
  assign fwd_hit1 = we_q && (waddr_q == fwd_addr1);
  assign fwd_hit2 = we_q && (waddr_q == fwd_addr2);
  assign fwd_data = wdata_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb/tb_regfile_wr_arb.sv - randomized and directed checks of regfile_wr_arb against a reference model
module tb_regfile_wr_arb;

  localparam int NREQ     = 3;
  localparam int LOCK_MAX = 2;
  localparam int BOUND    = (NREQ - 1) * LOCK_MAX + 1;

  logic                     clk;
  logic                     reset_n;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_lock;
  logic [NREQ-1:0][4:0]     req_addr;
  logic [NREQ-1:0][63:0]    req_data;
  logic [NREQ-1:0]          req_ready;
  logic                     RegWrite;
  logic [4:0]               WriteRegister;
  logic [63:0]              WriteData;
`ifdef RF_ARB_FWD_EN
  logic [4:0]               fwd_addr1;
  logic [4:0]               fwd_addr2;
  logic                     fwd_hit1;
  logic                     fwd_hit2;
  logic [63:0]              fwd_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who holds the lock and how many grants it has used so far
  bit          m_locked;
  int          m_owner;
  int          m_held;
  int          m_ptr;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [63:0] m_data;

  regfile_wr_arb #(.NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_lock      (req_lock),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData)
`ifdef RF_ARB_FWD_EN
    ,
    .fwd_addr1     (fwd_addr1),
    .fwd_addr2     (fwd_addr2),
    .fwd_hit1      (fwd_hit1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data      (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_grant();
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_commit(input int g);
    if (g < 0) begin
      m_we     = 1'b0;
      m_locked = 1'b0;
      return;
    end
    m_we   = (req_addr[g] != 5'd31);
    m_addr = req_addr[g];
    m_data = req_data[g];
    m_ptr  = (g + 1) % NREQ;
    if (m_locked) begin
      m_held = m_held + 1;
      if (!(req_lock[g] && m_held < LOCK_MAX)) m_locked = 1'b0;
    end else if (req_lock[g] && LOCK_MAX > 1) begin
      m_locked = 1'b1;
      m_owner  = g;
      m_held   = 1;
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_data  = '0;
`ifdef RF_ARB_FWD_EN
    fwd_addr1 = '0;
    fwd_addr2 = '0;
`endif
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    m_locked = 1'b0; m_owner = 0; m_held = 0; m_ptr = 0;
    m_we = 1'b0; m_addr = '0; m_data = '0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = '1;
    req_lock  = '0;
    req_addr  = '0;
    req_data  = '0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    n_tests++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 64'd0) begin
      n_fail++; $display("FAIL reset_stage got=%b/%0d/%h exp=0/0/0", RegWrite, WriteRegister, WriteData);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=001", req_ready); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i] = 5'(i + 1);
      req_data[i] = 64'(i + 100);
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_tests++;
      if (req_ready !== 3'(1 << (c % 3))) begin
        n_fail++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, 3'(1 << (c % 3)));
      end
      if (c > 0) begin
        n_tests++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'((c - 1) % 3 + 1)) begin
          n_fail++; $display("FAIL rr_stage c=%0d got=%b/%0d exp=1/%0d", c, RegWrite, WriteRegister, (c - 1) % 3 + 1);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_lock();
    logic [2:0] seq [0:6];
    seq = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b001, 3'b010, 3'b010};
    do_reset();
    req_valid = '1;
    req_lock  = 3'b010;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_tests++;
      if (req_ready !== seq[c]) begin n_fail++; $display("FAIL lock_seq c=%0d got=%b exp=%b", c, req_ready, seq[c]); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_lock_drop();
    do_reset();
    req_valid = '1;
    req_lock  = 3'b010;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 3'b010) begin n_fail++; $display("FAIL drop_lock_take got=%b exp=010", req_ready); end
    @(posedge clk); #1 req_valid = 3'b101;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 3'b000) begin n_fail++; $display("FAIL drop_no_grant got=%b exp=000", req_ready); end
    @(posedge clk); #1 req_valid = 3'b111;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 3'b100) begin n_fail++; $display("FAIL drop_resume got=%b exp=100", req_ready); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    req_valid   = 3'b001;
    req_addr[0] = 5'd31;
    req_data[0] = 64'hDEAD;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 3'b001) begin n_fail++; $display("FAIL zero_grant got=%b exp=001", req_ready); end
    @(posedge clk); #1 req_addr[0] = 5'd5; req_data[0] = 64'h55;
    @(negedge clk);
    n_tests++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd31 || WriteData !== 64'hDEAD) begin
      n_fail++; $display("FAIL zero_squash got=%b/%0d/%h exp=0/31/dead", RegWrite, WriteRegister, WriteData);
    end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_tests++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 64'h55) begin
      n_fail++; $display("FAIL zero_next got=%b/%0d/%h exp=1/5/55", RegWrite, WriteRegister, WriteData);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd5) begin
      n_fail++; $display("FAIL idle_hold got=%b/%0d exp=0/5", RegWrite, WriteRegister);
    end
  endtask

  task automatic test_mid_lock_reset();
    do_reset();
    req_valid   = 3'b010;
    req_lock    = 3'b010;
    req_addr[1] = 5'd9;
    @(negedge clk);
    @(posedge clk); #1;
    n_tests++;
    if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL midlock_staged got=%b exp=1", RegWrite); end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (RegWrite !== 1'b0 || req_ready !== 3'b000) begin
      n_fail++; $display("FAIL midlock_async got=%b/%b exp=0/000", RegWrite, req_ready);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    req_valid = 3'b111;
    req_lock  = 3'b000;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 3'b001) begin n_fail++; $display("FAIL midlock_release got=%b exp=001", req_ready); end
  endtask

`ifdef RF_ARB_FWD_EN
  task automatic test_forward();
    do_reset();
    req_valid   = 3'b001;
    req_addr[0] = 5'd7;
    req_data[0] = 64'h1234;
    fwd_addr1   = 5'd7;
    fwd_addr2   = 5'd31;
    @(posedge clk); #1 req_addr[0] = 5'd31;
    @(negedge clk);
    n_tests++;
    if (fwd_hit1 !== 1'b1 || fwd_data !== 64'h1234 || fwd_hit2 !== 1'b0) begin
      n_fail++; $display("FAIL fwd_hit got=%b/%h/%b exp=1/1234/0", fwd_hit1, fwd_data, fwd_hit2);
    end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_tests++;
    if (fwd_hit2 !== 1'b0 || WriteRegister !== 5'd31) begin
      n_fail++; $display("FAIL fwd_zero got=%b/%0d exp=0/31", fwd_hit2, WriteRegister);
    end
  endtask
`endif

  task automatic test_random();
    int g;
    int waits [NREQ];
    int max_wait;
    logic [NREQ-1:0] exp_rdy;
    max_wait = 0;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom_range(0, 7) | $urandom_range(0, 7));
      req_lock  = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_addr[i] = 5'($urandom_range(0, 31));
        req_data[i] = {$urandom, $urandom};
      end
      @(negedge clk);
      g = exp_grant();
      exp_rdy = (g < 0) ? '0 : NREQ'(1 << g);
      n_tests++;
      if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      n_tests++;
      if (RegWrite !== m_we || WriteRegister !== m_addr || WriteData !== m_data) begin
        n_fail++; $display("FAIL rand_stage c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, RegWrite, WriteRegister, WriteData, m_we, m_addr, m_data);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !req_ready[i]) waits[i]++;
        else waits[i] = 0;
        if (waits[i] > max_wait) max_wait = waits[i];
      end
      @(posedge clk);
      model_commit(g);
      #1;
    end
    n_tests++;
    if (max_wait > BOUND - 1) begin n_fail++; $display("FAIL fairness got=%0d exp<=%0d", max_wait, BOUND - 1); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_lock_drop();
    test_zero_reg();
    test_mid_lock_reset();
`ifdef RF_ARB_FWD_EN
    test_forward();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
